// File: rtl/sram_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM controller.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam logic HALF_LOW  = 1'b0;
  localparam logic HALF_HIGH = 1'b1;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
  localparam int          SRAM_DW           = 16;

endpackage

// File: rtl/sram_wait_counter.sv
// 4-bit loadable phase counter; tc flags the final cycle of a half-transfer phase.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic [3:0] count,
  output logic       tc
);

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (clr) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (en) begin
      count <= count + 4'd1;
    end
  end

  assign tc = (count == 4'(WAIT_CYCLES));

endmodule

// File: rtl/sram_controller.sv
// MEM-stage controller moving 32-bit words to a 16-bit async SRAM as two halves.
// Optional address range check enabled by defining SRAM_ADDR_CHECK_EN.
module sram_controller
  import sram_pkg::*;
#(
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               addr_err
);

  state_t state, next_state;

  logic        req;
  logic [31:0] offset;
  logic        out_of_range;
  logic        in_phase;
  logic        cnt_clr;
  logic        tc;
  logic [3:0]  wait_count;
  logic        unused_bits;

  assign req      = rd_en | wr_en;
  assign offset   = address - BASE_ADDR;
  assign in_phase = (state == LOW) || (state == HIGH);
  // Low and high phases each restart the count, so a clear on tc suffices.
  assign cnt_clr  = (state == IDLE) || (state == DONE) || tc;

`ifdef SRAM_ADDR_CHECK_EN
  assign out_of_range = (address < BASE_ADDR) || (|offset[31:SRAM_AW+1]);
`else
  assign out_of_range = 1'b0;
`endif

  assign unused_bits = ^{offset[31:SRAM_AW+1], offset[1:0], wait_count};

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .en        (1'b1),
    .load      (1'b0),
    .load_value(4'd0),
    .count     (wait_count),
    .tc        (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    next_state  = state;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    addr_err    = 1'b0;

    case (state)
      IDLE: if (req) next_state = out_of_range ? DONE : LOW;
      LOW:  if (tc)  next_state = HIGH;
      HIGH: if (tc)  next_state = DONE;
      DONE: begin
        next_state = IDLE;
        addr_err   = out_of_range;
      end
    endcase

    if (in_phase) begin
      sram_addr = {offset[SRAM_AW:2], (state == HIGH) ? HALF_HIGH : HALF_LOW};
      if (wr_en) begin
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state == HIGH) ? write_data[31:16] : write_data[15:0];
        sram_we_n   = tc;  // strobe released in the final cycle for hold time
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

  assign ready = ((state == IDLE) && !req) || (state == DONE);

  // Write wins when both requests are set, so read capture requires ~wr_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= 32'd0;
    end else if (tc && rd_en && !wr_en) begin
      if (state == LOW)  read_data[15:0]  <= sram_dq_in;
      if (state == HIGH) read_data[31:16] <= sram_dq_in;
    end
  end

endmodule
